udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

Round-robin scheduler that shares one UDP/GMII frame generator (`packet_gen`) between `NUM_CH` AXI-Stream payload sources. Each channel supplies its own payload length and destination UDP port. The arbiter grants one channel per frame and loads that channel's header configuration into the generator before any payload moves. It forwards exactly the configured number of payload beats, then holds off the next grant until the frame has left the wire and an inter-frame gap has elapsed.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesting channels (≥2).
- `DATA_WIDTH`, 8: AXIS data width; one beat = one payload byte.
- `PAYLOAD_WIDTH`, 11: width of payload byte counts.
- `IFG_CYCLES`, 12: idle cycles enforced after `tx_en_i` falls.

Ports (one clock; reset is synchronous, active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `s_axis_tdata_i`  in  NUM_CH*DATA_WIDTH  channel data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid_i`  in  NUM_CH  per-channel valid.
- `s_axis_tlast_i`  in  NUM_CH  per-channel last.
- `s_axis_tready_o`  out  NUM_CH  per-channel ready.
- `cfg_payload_i`  in  NUM_CH*PAYLOAD_WIDTH  per-channel payload bytes; 0 = channel disabled.
- `cfg_port_i`  in  NUM_CH*16  per-channel destination UDP port.
- `m_axis_tdata_o`  out  DATA_WIDTH  data to generator.
- `m_axis_tvalid_o`  out  1  valid to generator.
- `m_axis_tlast_o`  out  1  high on final counted beat.
- `m_axis_tready_i`  in  1  generator ready.
- `payload_bytes_o`  out  PAYLOAD_WIDTH  latched length for the generator.
- `host_port_o`  out  16  latched destination port for the generator.
- `tx_en_i`  in  1  generator GMII transmit enable; used for frame-end detection.
- `grant_o`  out  NUM_CH  one-hot current grant; 0 when idle.
- `busy_o`  out  1  high in every state except IDLE.
- `err_o`  out  NUM_CH  one-cycle pulse on a tlast mismatch for that channel.

## Operation
- States: IDLE → LOAD → SEND → DRAIN → GAP → IDLE.
- **Eligibility:** channel k is eligible when `s_axis_tvalid_i[k]` is high and `cfg_payload_i[k] != 0`.
- **IDLE:** if any channel is eligible, grant the first eligible one searching from `last+1` with modulo-`NUM_CH` wrap. Register the one-hot `grant_o` and set `last` = the granted index. Go to LOAD.
- **LOAD** (1 cycle): latch the granted channel's `cfg_payload_i` into `payload_bytes_o` and `cfg_port_i` into `host_port_o`. Clear the beat counter. Go to SEND.
  - Config changes after LOAD do not affect the current frame.
- **SEND:** combinational pass-through of the granted channel only.
  - `m_axis_tdata_o`/`m_axis_tvalid_o` follow the granted channel's inputs.
  - `s_axis_tready_o[g]` = `m_axis_tready_i`; all other readies are 0.
  - The beat counter increments on each accepted beat (valid & ready).
  - `m_axis_tlast_o` = tvalid & (count == `payload_bytes_o` − 1).
  - After the final beat is accepted, go to DRAIN.
  - Input tlast is ignored for termination. Pulse `err_o[g]` in the cycle after the mismatching beat is accepted when:
    - tlast is high on a non-final beat, or
    - tlast is low on the final beat.
- **DRAIN:** all readies are 0. Wait for `tx_en_i` to have been seen high (a sticky flag set in SEND or DRAIN), then wait for `tx_en_i` low. Go to GAP and clear the flag.
- **GAP:** count `IFG_CYCLES`, then go to IDLE. `grant_o` clears on GAP entry.
- **Counters:** `$clog2(IFG_CYCLES+1)` bits for the gap; `PAYLOAD_WIDTH` bits for beats. The beat count never wraps because termination occurs at `payload_bytes_o`.

## Timing
- Reset values: state = IDLE, `last` = NUM_CH−1 (channel 0 has first priority), `grant_o` = 0, `busy_o` = 0, `err_o` = 0, all `s_axis_tready_o` = 0, `m_axis_tvalid_o` = 0, `m_axis_tlast_o` = 0, `payload_bytes_o` = 0, `host_port_o` = 0.
- Grant latency:
  - tvalid sampled in IDLE at cycle N → `grant_o` valid at N+1 (LOAD).
  - `payload_bytes_o`/`host_port_o` valid at N+2.
  - First possible ready at N+2 (SEND).
- Throughput: 1 beat/cycle in SEND when source and generator are both ready. Backpressure on either side stalls without loss.
- Simultaneous requests: strict round-robin. A channel that just finished is served last among the contenders.
- A request is never preempted. A channel dropping tvalid mid-frame stalls SEND indefinitely; no timeout.
- Reset asserted in any state returns all outputs to reset values on the next edge, including mid-frame.

## Test plan
1. Ch0 only, cfg_payload=4, port=17767, bytes 0xA0..0xA3 with tlast on the 4th byte:
   - `payload_bytes_o`=4 and `host_port_o`=17767 before the first ready.
   - Exactly 4 beats forwarded, `m_axis_tlast_o` on 0xA3.
   - The next grant comes no earlier than 12 cycles after `tx_en_i` falls.
2. Ch0..ch3 all valid from reset, payloads 2/3/4/5: grant order 0,1,2,3,0. Each frame carries its own length and port.
3. Ch1 cfg_payload=0 with tvalid high, ch2 valid: ch1 is never granted and its ready stays 0; ch2 is served.
4. Ch0 cfg_payload=3, tlast on the 2nd byte: `err_o[0]` pulses once and 3 beats are still forwarded. Repeat with tlast absent on the 3rd byte: `err_o[0]` pulses.
5. Random `m_axis_tready_i` (50%) and source tvalid gaps on ch3, payload=340: all 340 bytes arrive in order, and tlast appears only on byte 340.
6. Assert `rst_i` during SEND of beat 5 of 10: all outputs return to reset values next cycle. After release, ch0 is granted first with a fresh LOAD.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin share of one UDP frame generator among NUM_CH AXI-Stream payload sources
module udp_tx_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int PAYLOAD_WIDTH = 11,
  parameter int IFG_CYCLES    = 12
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic [NUM_CH-1:0]               s_axis_tvalid_i,
  input  logic [NUM_CH-1:0]               s_axis_tlast_i,
  output logic [NUM_CH-1:0]               s_axis_tready_o,
  input  logic [NUM_CH*PAYLOAD_WIDTH-1:0] cfg_payload_i,
  input  logic [NUM_CH*16-1:0]            cfg_port_i,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata_o,
  output logic                            m_axis_tvalid_o,
  output logic                            m_axis_tlast_o,
  input  logic                            m_axis_tready_i,
  output logic [PAYLOAD_WIDTH-1:0]        payload_bytes_o,
  output logic [15:0]                     host_port_o,
  input  logic                            tx_en_i,
  output logic [NUM_CH-1:0]               grant_o,
  output logic                            busy_o,
  output logic [NUM_CH-1:0]               err_o
);
  localparam int IW = $clog2(NUM_CH);
  localparam int GW = $clog2(IFG_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, GAP} state_t;
  state_t                   r_state;
  logic [IW-1:0]            r_last, w_idx, w_j;
  logic [NUM_CH-1:0]        r_grant, r_err, w_elig;
  logic [PAYLOAD_WIDTH-1:0] r_payload, r_cnt;
  logic [15:0]              r_port;
  logic [GW-1:0]            r_gap;
  logic                     r_seen, w_found, w_send, w_valid, w_acc, w_final;
  logic [DATA_WIDTH-1:0]    w_data [NUM_CH];
  logic [PAYLOAD_WIDTH-1:0] w_pay  [NUM_CH];
  logic [15:0]              w_port [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_data[g] = s_axis_tdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_pay[g]  = cfg_payload_i[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    assign w_port[g] = cfg_port_i[g*16 +: 16];
    assign w_elig[g] = s_axis_tvalid_i[g] & (|w_pay[g]);
  end
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_j = IW'((int'(r_last) + i) % NUM_CH);
      if (!w_found && w_elig[w_j]) begin
        w_found = 1'b1;
        w_idx   = w_j;
      end
    end
  end
  assign w_send          = r_state == SEND;
  assign w_valid         = w_send & s_axis_tvalid_i[r_last];
  assign w_final         = r_cnt == r_payload - PAYLOAD_WIDTH'(1);
  assign w_acc           = w_valid & m_axis_tready_i;
  assign m_axis_tdata_o  = w_send ? w_data[r_last] : '0;
  assign m_axis_tvalid_o = w_valid;
  assign m_axis_tlast_o  = w_valid & w_final;
  assign s_axis_tready_o = w_send ? r_grant & {NUM_CH{m_axis_tready_i}} : '0;
  assign payload_bytes_o = r_payload;
  assign host_port_o     = r_port;
  assign grant_o         = r_grant;
  assign busy_o          = r_state != IDLE;
  assign err_o           = r_err;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_last    <= IW'(NUM_CH - 1);
      r_grant   <= '0;
      r_err     <= '0;
      r_payload <= '0;
      r_port    <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_seen    <= 1'b0;
    end else begin
      r_err <= (w_acc && (s_axis_tlast_i[r_last] ^ w_final)) ? r_grant : '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_grant <= NUM_CH'(1) << w_idx;
          r_last  <= w_idx;
          r_state <= LOAD;
        end
        LOAD: begin
          r_payload <= w_pay[r_last];
          r_port    <= w_port[r_last];
          r_cnt     <= '0;
          r_seen    <= 1'b0;
          r_state   <= SEND;
        end
        SEND: begin
          r_seen <= r_seen | tx_en_i;
          if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_final) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_seen <= r_seen | tx_en_i;
          if (r_seen && !tx_en_i) begin
            r_seen  <= 1'b0;
            r_grant <= '0;
            r_gap   <= '0;
            r_state <= GAP;
          end
        end
        GAP: begin
          r_gap <= r_gap + 1'b1;
          if (int'(r_gap) + 1 >= IFG_CYCLES) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: scoreboard bench for udp_tx_arbiter
module tb_udp_tx_arbiter;
  localparam int N = 4, DW = 8, PW = 11, IFG = 12;
  logic clk = 1'b0, rst_i = 1'b1;
  always #5 clk = ~clk;
  logic [N*DW-1:0] tdata;
  logic [N-1:0] tvalid, tlast, tready, grant, err;
  logic [N*PW-1:0] cfg_pay = '0;
  logic [N*16-1:0] cfg_port = '0;
  logic [DW-1:0] m_data;
  logic m_valid, m_last, m_ready, tx_en, busy;
  logic [PW-1:0] pay;
  logic [15:0] port;
  udp_tx_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW), .IFG_CYCLES(IFG)) dut (
    .clk_i(clk), .rst_i(rst_i), .s_axis_tdata_i(tdata), .s_axis_tvalid_i(tvalid),
    .s_axis_tlast_i(tlast), .s_axis_tready_o(tready), .cfg_payload_i(cfg_pay),
    .cfg_port_i(cfg_port), .m_axis_tdata_o(m_data), .m_axis_tvalid_o(m_valid),
    .m_axis_tlast_o(m_last), .m_axis_tready_i(m_ready), .payload_bytes_o(pay),
    .host_port_o(port), .tx_en_i(tx_en), .grant_o(grant), .busy_o(busy), .err_o(err));
  logic [8:0] srcq [N][$];
  logic [8:0] expq [$];
  int expg [$], expp [$], expo [$];
  int tests = 0, fails = 0, cyc = 0, fall = -1, txc = 0, nbeats = 0, cur_p = 0, cur_o = 0;
  int errcnt [N];
  bit hs [N];
  bit gap_en [N];
  bit rnd_ready = 0, exact_gap = 0, rdy1_seen = 0, pend = 0;
  logic [N-1:0] prev_grant = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic setcfg(input int k, input int p, input int o);
    cfg_pay[k*PW +: PW] = PW'(p);
    cfg_port[k*16 +: 16] = 16'(o);
  endtask
  // lmode 0: tlast on final byte, 1: tlast on 2nd and final byte, 2: never tlast
  task automatic frame(input int k, input int n, input int o, input int base, input int lmode);
    for (int i = 0; i < n; i++) begin
      logic l;
      l = (lmode == 0) ? (i == n - 1) : (lmode == 1) ? (i == 1 || i == n - 1) : 1'b0;
      srcq[k].push_back({l, 8'(base + i)});
      expq.push_back({1'(i == n - 1), 8'(base + i)});
    end
    expg.push_back(k);
    expp.push_back(n);
    expo.push_back(o);
  endtask
  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 5000; i++) begin
      @(negedge clk); #2;
      if (expq.size() == 0 && expg.size() == 0 && !busy && txc == 0) break;
    end
    chk({name, "_done"}, 32'(i < 5000), 1);
  endtask
  task automatic do_reset();
    @(negedge clk); #2;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_i = 1'b0;
  endtask
  task automatic chk_reset(input string name);
    chk({name, "_grant"}, grant, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_ready"}, tready, 0);
    chk({name, "_mvalid"}, m_valid, 0);
    chk({name, "_mlast"}, m_last, 0);
    chk({name, "_payload"}, pay, 0);
    chk({name, "_port"}, port, 0);
  endtask
  initial begin
    tvalid = '0; tdata = '0; tlast = '0; m_ready = 1'b1;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (hs[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < N; k++) begin
        tvalid[k] = (srcq[k].size() > 0) && !(gap_en[k] && $urandom_range(0, 1) == 0);
        tdata[k*DW +: DW] = (srcq[k].size() > 0) ? srcq[k][0][7:0] : '0;
        tlast[k] = (srcq[k].size() > 0) ? srcq[k][0][8] : 1'b0;
      end
      #1;
      for (int k = 0; k < N; k++) hs[k] = tvalid[k] & tready[k] & !rst_i;
    end
  end
  initial begin
    tx_en = 1'b0;
    for (int k = 0; k < N; k++) errcnt[k] = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (rst_i) begin
        txc = 0; tx_en = 1'b0; pend = 0;
      end else begin
        if (pend) begin
          chk("load_payload", pay, cur_p);
          chk("load_port", port, cur_o);
          pend = 0;
        end
        if (prev_grant == 0 && grant != 0) begin
          if (expg.size() == 0) chk("unexpected_grant", grant, 0);
          else begin
            chk("grant", grant, 32'(1) << expg.pop_front());
            cur_p = expp.pop_front();
            cur_o = expo.pop_front();
            pend = 1;
            if (fall >= 0) begin
              if (exact_gap) chk("gap_exact", cyc - fall, 14);
              else chk("gap_min", 32'(cyc - fall >= 14), 1);
              fall = -1;
            end
          end
        end
        if (tready[1]) rdy1_seen = 1;
        for (int k = 0; k < N; k++) errcnt[k] += int'(err[k]);
        if (txc > 0) begin
          txc++;
          tx_en = (txc >= 3 && txc <= 7);
          if (txc == 8) begin fall = cyc; txc = 0; end
        end
        if (m_valid && m_ready) begin
          nbeats++;
          if (expq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: got %0h expected none", {m_last, m_data});
          end else chk("beat", {m_last, m_data}, expq.pop_front());
          if (m_last) txc = 1;
        end
      end
      prev_grant = grant;
    end
  end
  initial begin
    int e0, base;
    repeat (3) @(negedge clk);
    #2 chk_reset("reset");
    rst_i = 1'b0;
    exact_gap = 1;
    setcfg(0, 4, 17767);
    frame(0, 4, 17767, 'hA0, 0);
    frame(0, 4, 17767, 'hA4, 0);
    wait_done("t1");
    exact_gap = 0;
    do_reset();
    for (int k = 0; k < N; k++) setcfg(k, k + 2, 1000 + k);
    frame(0, 2, 1000, 'h10, 0);
    frame(1, 3, 1001, 'h20, 0);
    frame(2, 4, 1002, 'h30, 0);
    frame(3, 5, 1003, 'h40, 0);
    frame(0, 2, 1000, 'h18, 0);
    wait_done("t2");
    cfg_pay = '0;
    setcfg(1, 0, 2001);
    setcfg(2, 3, 2002);
    rdy1_seen = 0;
    for (int i = 0; i < 3; i++) srcq[1].push_back({1'(i == 2), 8'('hB0 + i)});
    frame(2, 3, 2002, 'h50, 0);
    wait_done("t3");
    repeat (20) @(negedge clk);
    #2 chk("t3_idle", busy, 0);
    chk("t3_ch1_ready", 32'(rdy1_seen), 0);
    srcq[1].delete();
    cfg_pay = '0;
    setcfg(0, 3, 3000);
    e0 = errcnt[0];
    frame(0, 3, 3000, 'h60, 1);
    wait_done("t4a");
    chk("t4a_err", errcnt[0] - e0, 1);
    e0 = errcnt[0];
    frame(0, 3, 3000, 'h68, 2);
    wait_done("t4b");
    chk("t4b_err", errcnt[0] - e0, 1);
    chk("t4_err_other", errcnt[1] + errcnt[2] + errcnt[3], 0);
    cfg_pay = '0;
    setcfg(3, 340, 4000);
    rnd_ready = 1; gap_en[3] = 1;
    frame(3, 340, 4000, 0, 0);
    wait_done("t5");
    rnd_ready = 0; gap_en[3] = 0;
    cfg_pay = '0;
    setcfg(0, 10, 5000);
    setcfg(1, 2, 5001);
    base = nbeats;
    frame(0, 10, 5000, 'h70, 0);
    for (int i = 0; i < 2000 && nbeats < base + 5; i++) begin @(negedge clk); #2; end
    chk("t6_reach_beat5", nbeats - base, 5);
    rst_i = 1'b1;
    @(negedge clk); #2;
    chk_reset("t6_rst");
    for (int k = 0; k < N; k++) srcq[k].delete();
    expq.delete(); expg.delete(); expp.delete(); expo.delete();
    frame(0, 10, 5000, 'h80, 0);
    frame(1, 2, 5001, 'h90, 0);
    rst_i = 1'b0;
    wait_done("t6");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
